rv32_memory: RTL and testbench

- Memory stage of the RV32 pipeline; receiving end of the execute-to-memory pipe register.
- Takes the registered address (ALU result), store data and size/sign info from instr funct3.
- Performs loads/stores over a req/gnt/rvalid data bus and drives stall_m_o back to the execute stage so the E/M register holds while an access is in flight.
- Aligns and extends load data, then registers everything into the memory-to-writeback pipe.

---
 rtl/rv32_memory.sv | 183 ++++++++++++++++++
 tb/tb_rv32_memory.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_memory.sv
// RV32 memory stage: data-bus load/store sequencing, load alignment/extension and the M/W pipe register.
// Optional macro RV32_DBUS_TIMEOUT_EN adds an 8-bit bus timeout that ends a hung access with an access fault.
module rv32_memory #(
   parameter int         EXC_WIDTH       = 8,
   parameter int         EXC_LD_MISALIGN = 4,
   parameter int         EXC_ST_MISALIGN = 6,
   parameter logic [2:0] RS_LOAD         = 3'b001
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 reg_write_i,
   input  logic                 fp_reg_write_i,
   input  logic                 memory_write_i,
   input  logic [2:0]           result_source_i,
   input  logic [EXC_WIDTH-1:0] exceptions_i,
   input  logic [31:0]          instr_i,
   input  logic [31:0]          pc_next_i,
   input  logic [31:0]          alu_result_i,
   input  logic [31:0]          write_data_i,
   input  logic [31:0]          fpu_result_i,
   output logic                 stall_m_o,
   output logic                 dbus_req_o,
   output logic                 dbus_we_o,
   output logic [31:0]          dbus_addr_o,
   output logic [3:0]           dbus_be_o,
   output logic [31:0]          dbus_wdata_o,
   input  logic                 dbus_gnt_i,
   input  logic                 dbus_rvalid_i,
   input  logic [31:0]          dbus_rdata_i,
   output logic                 reg_write_o,
   output logic                 fp_reg_write_o,
   output logic [2:0]           result_source_o,
   output logic [EXC_WIDTH-1:0] exceptions_o,
   output logic [31:0]          instr_o,
   output logic [31:0]          pc_next_o,
   output logic [31:0]          alu_result_o,
   output logic [31:0]          fpu_result_o,
   output logic [31:0]          load_data_o
);

   typedef enum logic {S_IDLE, S_WAIT_RVALID} state_t;
   state_t r_state;

   logic [2:0]           w_funct3;
   logic                 w_is_load, w_is_store, w_is_half, w_is_word;
   logic                 w_misaligned, w_access, w_req, w_ld_gnt;
   logic                 w_done_ok, w_timeout, w_complete, w_stall;
   logic [3:0]           w_be;
   logic [31:0]          w_wdata, w_rshift, w_ld, w_ld_commit;
   logic [EXC_WIDTH-1:0] w_exc;

   assign w_funct3     = instr_i[14:12];
   assign w_is_load    = (result_source_i == RS_LOAD);
   assign w_is_store   = memory_write_i;
   assign w_is_half    = (w_funct3[1:0] == 2'b01);
   assign w_is_word    = w_funct3[1];
   assign w_misaligned = (w_is_load | w_is_store) &
                         ((w_is_half & alu_result_i[0]) | (w_is_word & (alu_result_i[1:0] != 2'b00)));
   assign w_access     = (w_is_load | w_is_store) & ~w_misaligned & (exceptions_i == '0);

   // E/M holds its contents while stalled, so the request can be driven straight from its outputs
   assign w_req     = rst_n_i & w_access & (r_state == S_IDLE);
   assign w_ld_gnt  = w_req & ~w_is_store & dbus_gnt_i;
   assign w_done_ok = (r_state == S_IDLE) ? (w_req & w_is_store & dbus_gnt_i) : dbus_rvalid_i;

`ifdef RV32_DBUS_TIMEOUT_EN
   logic [7:0] r_timer;

   assign w_timeout = w_access & (r_timer == 8'hFF) & ~w_done_ok & ~w_ld_gnt;

   // The grant restarts the window so the read-data phase gets its own full budget
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_timer <= '0;
      else if (w_complete || w_ld_gnt || !w_access)
         r_timer <= '0;
      else
         r_timer <= r_timer + 8'd1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   assign w_complete = w_done_ok | w_timeout;
   assign w_stall    = rst_n_i & w_access & ~w_complete;
   assign stall_m_o  = w_stall;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:        if (w_ld_gnt)   r_state <= S_WAIT_RVALID;
            S_WAIT_RVALID: if (w_complete) r_state <= S_IDLE;
            default:                       r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = write_data_i;
      if (w_funct3[1:0] == 2'b00) begin
         w_be    = 4'b0001 << alu_result_i[1:0];
         w_wdata = {4{write_data_i[7:0]}};
      end else if (w_funct3[1:0] == 2'b01) begin
         w_be    = 4'b0011 << alu_result_i[1:0];
         w_wdata = {2{write_data_i[15:0]}};
      end
   end

   assign dbus_req_o   = w_req;
   assign dbus_we_o    = w_req & w_is_store;
   assign dbus_addr_o  = w_req ? {alu_result_i[31:2], 2'b00} : 32'h0;
   assign dbus_be_o    = w_req ? w_be : 4'b0000;
   assign dbus_wdata_o = w_req ? w_wdata : 32'h0;

   assign w_rshift = dbus_rdata_i >> {alu_result_i[1:0], 3'b000};

   always_comb begin
      case (w_funct3[1:0])
         2'b00:   w_ld = {{24{~w_funct3[2] & w_rshift[7]}}, w_rshift[7:0]};
         2'b01:   w_ld = {{16{~w_funct3[2] & w_rshift[15]}}, w_rshift[15:0]};
         default: w_ld = w_rshift;
      endcase
   end

   assign w_ld_commit = ((r_state == S_WAIT_RVALID) && dbus_rvalid_i) ? w_ld : 32'h0;

   always_comb begin
      w_exc = exceptions_i;
      if (w_misaligned & w_is_load)  w_exc[EXC_LD_MISALIGN] = 1'b1;
      if (w_misaligned & w_is_store) w_exc[EXC_ST_MISALIGN] = 1'b1;
      if (w_timeout & w_is_store)
         w_exc[EXC_ST_MISALIGN+1] = 1'b1;
      else if (w_timeout)
         w_exc[EXC_LD_MISALIGN+1] = 1'b1;
   end

   logic                 r_reg_write, r_fp_reg_write;
   logic [2:0]           r_result_source;
   logic [EXC_WIDTH-1:0] r_exceptions;
   logic [31:0]          r_instr, r_pc_next, r_alu_result, r_fpu_result, r_load_data;

   // Stalled cycles leave a bubble (write enables low) so the held instruction commits exactly once
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_reg_write     <= 1'b0;
         r_fp_reg_write  <= 1'b0;
         r_result_source <= '0;
         r_exceptions    <= '0;
         r_instr         <= '0;
         r_pc_next       <= '0;
         r_alu_result    <= '0;
         r_fpu_result    <= '0;
         r_load_data     <= '0;
      end else if (!w_stall) begin
         r_reg_write     <= reg_write_i & ~w_misaligned & ~w_timeout;
         r_fp_reg_write  <= fp_reg_write_i & ~w_misaligned & ~w_timeout;
         r_result_source <= result_source_i;
         r_exceptions    <= w_exc;
         r_instr         <= instr_i;
         r_pc_next       <= pc_next_i;
         r_alu_result    <= alu_result_i;
         r_fpu_result    <= fpu_result_i;
         r_load_data     <= w_ld_commit;
      end else begin
         r_reg_write     <= 1'b0;
         r_fp_reg_write  <= 1'b0;
      end
   end

   assign reg_write_o     = r_reg_write;
   assign fp_reg_write_o  = r_fp_reg_write;
   assign result_source_o = r_result_source;
   assign exceptions_o    = r_exceptions;
   assign instr_o         = r_instr;
   assign pc_next_o       = r_pc_next;
   assign alu_result_o    = r_alu_result;
   assign fpu_result_o    = r_fpu_result;
   assign load_data_o     = r_load_data;

endmodule

// File: tb/tb_rv32_memory.sv
// Randomized self-checking bench for rv32_memory against a transaction-level model of the memory stage.
// Define RV32_DBUS_TIMEOUT_EN to also exercise the bus timeout path.
module tb_rv32_memory;

   localparam logic [2:0] RS_LOAD = 3'b001;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        reg_write_i, fp_reg_write_i, memory_write_i;
   logic [2:0]  result_source_i;
   logic [7:0]  exceptions_i;
   logic [31:0] instr_i, pc_next_i, alu_result_i, write_data_i, fpu_result_i;
   logic        stall_m_o, dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o;
   logic [3:0]  dbus_be_o;
   logic        dbus_gnt_i, dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;
   logic        reg_write_o, fp_reg_write_o;
   logic [2:0]  result_source_o;
   logic [7:0]  exceptions_o;
   logic [31:0] instr_o, pc_next_o, alu_result_o, fpu_result_o, load_data_o;

   always #5 clk_i = ~clk_i;

   rv32_memory dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .reg_write_i(reg_write_i), .fp_reg_write_i(fp_reg_write_i), .memory_write_i(memory_write_i),
      .result_source_i(result_source_i), .exceptions_i(exceptions_i), .instr_i(instr_i),
      .pc_next_i(pc_next_i), .alu_result_i(alu_result_i), .write_data_i(write_data_i),
      .fpu_result_i(fpu_result_i), .stall_m_o(stall_m_o), .dbus_req_o(dbus_req_o),
      .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
      .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
      .dbus_rdata_i(dbus_rdata_i), .reg_write_o(reg_write_o), .fp_reg_write_o(fp_reg_write_o),
      .result_source_o(result_source_o), .exceptions_o(exceptions_o), .instr_o(instr_o),
      .pc_next_o(pc_next_o), .alu_result_o(alu_result_o), .fpu_result_o(fpu_result_o),
      .load_data_o(load_data_o)
   );

   typedef struct packed {
      logic rw, frw, mw; logic [2:0] rs; logic [7:0] exc;
      logic [31:0] instr, pc, alu, wd, fpu;
   } txn_t;

   typedef struct packed {
      logic rw, frw; logic [2:0] rs; logic [7:0] exc;
      logic [31:0] instr, pc, alu, fpu, ld;
   } mw_t;

   int n_checks = 0, n_fail = 0;
   int n_stall_seen = 0, n_req_seen = 0;
   logic [3:0]  seen_be;
   logic [31:0] seen_wdata, seen_addr;
   logic        seen_we;

   logic        chk_en;
   logic        exp_req, exp_stall, exp_we;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_be;
   mw_t         exp_mw;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_mem(input txn_t t);
      return (t.rs == RS_LOAD) || t.mw;
   endfunction

   function automatic bit misal(input txn_t t);
      int off = int'(t.alu[1:0]);
      return is_mem(t) && ((off % nbytes(t.instr[14:12])) != 0);
   endfunction

   function automatic bit acc(input txn_t t);
      return is_mem(t) && !misal(t) && (t.exc == 8'h0);
   endfunction

   function automatic logic [3:0] be_of(input txn_t t);
      int n = nbytes(t.instr[14:12]);
      logic [7:0] v = 8'((1 << n) - 1) << t.alu[1:0];
      return v[3:0];
   endfunction

   function automatic logic [31:0] wdata_of(input txn_t t);
      int n = nbytes(t.instr[14:12]);
      if (n == 1) return 32'(t.wd[7:0]) * 32'h01010101;
      if (n == 2) return 32'(t.wd[15:0]) * 32'h00010001;
      return t.wd;
   endfunction

   function automatic logic [31:0] load_of(input txn_t t, input logic [31:0] rdata);
      int n = nbytes(t.instr[14:12]);
      logic [31:0] v = rdata >> (8 * int'(t.alu[1:0]));
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
      v = v & mask;
      if (!t.instr[14] && n < 4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic mw_t mw_of(input txn_t t, input logic [31:0] rdata);
      mw_t m;
      bit  ms = misal(t);
      m.rw    = t.rw && !ms;
      m.frw   = t.frw && !ms;
      m.rs    = t.rs;
      m.exc   = t.exc | ((ms && t.rs == RS_LOAD) ? 8'h10 : 8'h00) | ((ms && t.mw) ? 8'h40 : 8'h00);
      m.instr = t.instr;
      m.pc    = t.pc;
      m.alu   = t.alu;
      m.fpu   = t.fpu;
      m.ld    = (acc(t) && !t.mw) ? load_of(t, rdata) : 32'h0;
      return m;
   endfunction

   function automatic txn_t mk(input bit rw, input bit frw, input bit mw, input logic [2:0] rs,
                               input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd);
      txn_t t;
      t.rw = rw; t.frw = frw; t.mw = mw; t.rs = rs; t.exc = 8'h0;
      t.instr = $urandom; t.instr[14:12] = f3;
      t.pc = $urandom; t.alu = alu; t.wd = wd; t.fpu = $urandom;
      return t;
   endfunction

   task automatic apply(input txn_t t);
      reg_write_i = t.rw; fp_reg_write_i = t.frw; memory_write_i = t.mw;
      result_source_i = t.rs; exceptions_i = t.exc; instr_i = t.instr;
      pc_next_i = t.pc; alu_result_i = t.alu; write_data_i = t.wd; fpu_result_i = t.fpu;
   endtask

   task automatic set_bus_exp(input txn_t t);
      exp_we    = t.mw;
      exp_addr  = {t.alu[31:2], 2'b00};
      exp_be    = be_of(t);
      exp_wdata = wdata_of(t);
   endtask

   // Runs one E/M instruction until the model says it leaves the stage; g = gnt delay, r = rvalid delay after gnt
   task automatic run_txn(input txn_t t, input int g, input int r, input logic [31:0] rdata);
      bit st = acc(t) && t.mw;
      bit ld = acc(t) && !t.mw;
      bit done = 0;
      int k = 0;
      if (!acc(t)) begin g = 0; r = 0; end
      n_stall_seen = 0;
      n_req_seen = 0;
      while (!done) begin
         apply(t);
         set_bus_exp(t);
         if (st || ld) dbus_gnt_i = (k == g) ? 1'b1 : (ld && k > g) ? 1'($urandom) : 1'b0;
         else          dbus_gnt_i = 1'($urandom);
         if (ld) dbus_rvalid_i = (k == g + r) ? 1'b1 : (k <= g) ? 1'($urandom) : 1'b0;
         else    dbus_rvalid_i = 1'($urandom);
         dbus_rdata_i = (ld && k == g + r) ? rdata : $urandom;
         exp_req   = (st || ld) && (k <= g);
         exp_stall = st ? (k < g) : ld ? (k < g + r) : 1'b0;
         @(posedge clk_i); #1;
         if (exp_stall) begin
            exp_mw.rw = 1'b0; exp_mw.frw = 1'b0;
         end else begin
            exp_mw = mw_of(t, rdata);
            done = 1;
         end
         k++;
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_i) begin
      if (chk_en) begin
         if (stall_m_o) n_stall_seen++;
         if (dbus_req_o) begin
            n_req_seen++;
            seen_be = dbus_be_o; seen_wdata = dbus_wdata_o; seen_addr = dbus_addr_o; seen_we = dbus_we_o;
         end
         chk("req", dbus_req_o, exp_req);
         chk("stall", stall_m_o, exp_stall);
         if (exp_req) begin
            chk("we", dbus_we_o, exp_we);
            chk("addr", dbus_addr_o, exp_addr);
            chk("be", dbus_be_o, exp_be);
            chk("wdata", dbus_wdata_o, exp_wdata);
         end
         chk("mw_reg_write", reg_write_o, exp_mw.rw);
         chk("mw_fp_reg_write", fp_reg_write_o, exp_mw.frw);
         chk("mw_result_source", result_source_o, exp_mw.rs);
         chk("mw_exceptions", exceptions_o, exp_mw.exc);
         chk("mw_instr", instr_o, exp_mw.instr);
         chk("mw_pc_next", pc_next_o, exp_mw.pc);
         chk("mw_alu_result", alu_result_o, exp_mw.alu);
         chk("mw_fpu_result", fpu_result_o, exp_mw.fpu);
         chk("mw_load_data", load_data_o, exp_mw.ld);
      end
   end

   txn_t nop, t;

   initial begin
      nop = '0;
      chk_en = 1'b0;
      rst_n_i = 1'b0;
      apply(nop);
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
      exp_req = 1'b0; exp_stall = 1'b0; exp_mw = '0;
      exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_stall", stall_m_o, 1'b0);
      chk("reset_req", dbus_req_o, 1'b0);
      chk("reset_reg_write", reg_write_o, 1'b0);
      chk("reset_load_data", load_data_o, 32'h0);
      chk("reset_exceptions", exceptions_o, 8'h0);
      rst_n_i = 1'b1;
      chk_en = 1'b1;
      @(posedge clk_i); #1;

      // SW 0x100, granted immediately
      t = mk(0, 0, 1, 3'b000, 3'b010, 32'h100, 32'hDEADBEEF);
      run_txn(t, 0, 0, 32'h0);
      chk("sw_be", seen_be, 4'hF);
      chk("sw_we", seen_we, 1'b1);
      chk("sw_addr", seen_addr, 32'h100);
      chk("sw_wdata", seen_wdata, 32'hDEADBEEF);
      chk("sw_stall_cycles", n_stall_seen, 0);
      chk("sw_req_cycles", n_req_seen, 1);
      run_txn(nop, 0, 0, 32'h0);

      // LB 0x103, gnt cycle 0, rvalid cycle 2
      t = mk(1, 0, 0, RS_LOAD, 3'b000, 32'h103, 32'h0);
      run_txn(t, 0, 2, 32'h80FF_FF00);
      chk("lb_stall_cycles", n_stall_seen, 2);
      chk("lb_load_data", load_data_o, 32'hFFFF_FF80);
      chk("lb_reg_write", reg_write_o, 1'b1);

      // LHU 0x102
      t = mk(1, 0, 0, RS_LOAD, 3'b101, 32'h102, 32'h0);
      run_txn(t, 1, 1, 32'hBEEF_1234);
      chk("lhu_load_data", load_data_o, 32'h0000_BEEF);

      // SH 0x102
      t = mk(0, 0, 1, 3'b000, 3'b001, 32'h102, 32'h1234_ABCD);
      run_txn(t, 1, 0, 32'h0);
      chk("sh_be", seen_be, 4'b1100);
      chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);

      // LW 0x101: misaligned
      t = mk(1, 0, 0, RS_LOAD, 3'b010, 32'h101, 32'h0);
      run_txn(t, 0, 0, 32'h0);
      chk("lw_mis_req_cycles", n_req_seen, 0);
      chk("lw_mis_exc4", exceptions_o[4], 1'b1);
      chk("lw_mis_reg_write", reg_write_o, 1'b0);

      // Reset while waiting for rvalid, then a late rvalid
      chk_en = 1'b0;
      t = mk(1, 0, 0, RS_LOAD, 3'b010, 32'h200, 32'h0);
      apply(t);
      dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b0;
      @(posedge clk_i); #1;
      dbus_gnt_i = 1'b0;
      rst_n_i = 1'b0;
      #1;
      chk("midrst_stall", stall_m_o, 1'b0);
      chk("midrst_req", dbus_req_o, 1'b0);
      chk("midrst_addr", dbus_addr_o, 32'h0);
      chk("midrst_reg_write", reg_write_o, 1'b0);
      chk("midrst_alu_result", alu_result_o, 32'h0);
      chk("midrst_pc_next", pc_next_o, 32'h0);
      chk("midrst_exceptions", exceptions_o, 8'h0);
      apply(nop);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hCAFE_F00D;
      @(posedge clk_i); #1;
      dbus_rvalid_i = 1'b0;
      chk("late_rvalid_req", dbus_req_o, 1'b0);
      chk("late_rvalid_stall", stall_m_o, 1'b0);
      chk("late_rvalid_load_data", load_data_o, 32'h0);
      chk("late_rvalid_reg_write", reg_write_o, 1'b0);
      exp_mw = '0; exp_req = 1'b0; exp_stall = 1'b0;
      chk_en = 1'b1;
      t = mk(1, 0, 0, RS_LOAD, 3'b010, 32'h204, 32'h0);
      run_txn(t, 0, 1, 32'h1357_9BDF);
      chk("post_rst_lw_data", load_data_o, 32'h1357_9BDF);

`ifdef RV32_DBUS_TIMEOUT_EN
      // Load whose grant never comes
      t = mk(1, 0, 0, RS_LOAD, 3'b010, 32'h300, 32'h0);
      n_stall_seen = 0;
      for (int k = 0; k <= 255; k++) begin
         apply(t);
         set_bus_exp(t);
         dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
         exp_req = 1'b1;
         exp_stall = (k < 255);
         @(posedge clk_i); #1;
         if (exp_stall) begin
            exp_mw.rw = 1'b0; exp_mw.frw = 1'b0;
         end else begin
            exp_mw = mw_of(t, 32'h0);
            exp_mw.rw = 1'b0; exp_mw.frw = 1'b0;
            exp_mw.exc = exp_mw.exc | 8'h20;
            exp_mw.ld = 32'h0;
         end
      end
      chk("timeout_stall_cycles", n_stall_seen, 255);
      chk("timeout_exc5", exceptions_o[5], 1'b1);
      chk("timeout_reg_write", reg_write_o, 1'b0);
`endif

      // Random instruction stream
      for (int i = 0; i < 300; i++) begin
         int kind = int'($urandom_range(0, 4));
         logic [2:0] f3;
         logic [2:0] rs;
         f3 = {1'($urandom), 2'($urandom_range(0, 2))};
         case (kind)
            0: t = mk(1, 0, 0, RS_LOAD, f3, $urandom, $urandom);
            1: t = mk(0, 1, 0, RS_LOAD, 3'b010, $urandom, $urandom);
            2: t = mk(0, 0, 1, 3'b000, {1'b0, f3[1:0]}, $urandom, $urandom);
            3: begin
               rs = 3'($urandom_range(0, 6));
               if (rs >= 3'd1) rs = rs + 3'd1;
               t = mk(1'($urandom), 1'($urandom), 0, rs, f3, $urandom, $urandom);
            end
            default: t = mk(1, 1'($urandom), 1'($urandom), RS_LOAD, f3, $urandom, $urandom);
         endcase
         if (t.mw && t.rs == RS_LOAD) t.rs = 3'b000;
         if (kind <= 2 && $urandom_range(0, 9) < 7) begin
            if (nbytes(t.instr[14:12]) == 4) t.alu[1:0] = 2'b00;
            else if (nbytes(t.instr[14:12]) == 2) t.alu[0] = 1'b0;
         end
         if ($urandom_range(0, 7) == 0) t.exc = 8'($urandom_range(1, 255));
         run_txn(t, int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), $urandom);
      end

      run_txn(nop, 0, 0, 32'h0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
